// File: rtl/vdiff_pkg.sv
// vdiff_pkg: width helpers shared by the vector difference pipeline and its reduction tree.
package vdiff_pkg;

   // Lane index width; keeps at least one bit so a degenerate lane count still elaborates.
   function automatic int unsigned idx_w(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   // Exact sum width: LANES * (2**WIDTH - 1) always fits.
   function automatic int unsigned sum_w(input int unsigned width, input int unsigned lanes);
      return width + $clog2(lanes);
   endfunction

   // Width able to hold any count in 0..LANES.
   function automatic int unsigned cnt_w(input int unsigned lanes);
      return $clog2(lanes + 1);
   endfunction

   // Leaf count of the reduction tree, padded up to a power of two.
   function automatic int unsigned tree_leaves(input int unsigned lanes);
      return 1 << idx_w(lanes);
   endfunction

endpackage

// File: rtl/lane_reduce.sv
// lane_reduce: combinational balanced-tree reduction of per-lane differences into
// max, argmax (lowest index on ties), sum and over-threshold popcount.
module lane_reduce
   import vdiff_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LANES = 4,
   localparam int unsigned IDX_W = idx_w(LANES),
   localparam int unsigned SUM_W = sum_w(WIDTH, LANES),
   localparam int unsigned CNT_W = cnt_w(LANES)
) (
   input  logic [LANES*WIDTH-1:0] i_diff,
   input  logic [LANES-1:0]       i_over,
   output logic [WIDTH-1:0]       o_max,
   output logic [IDX_W-1:0]       o_idx,
   output logic [SUM_W-1:0]       o_sum,
   output logic [CNT_W-1:0]       o_cnt
);

   localparam int unsigned NLEAF = tree_leaves(LANES);

   // Padding leaves carry zero difference and a higher index than any real lane,
   // so with lower-index-wins ties they can never be selected.
   logic [NLEAF*WIDTH-1:0] w_diff_pad;
   logic [NLEAF-1:0]       w_over_pad;

   assign w_diff_pad = (NLEAF*WIDTH)'(i_diff);
   assign w_over_pad = NLEAF'(i_over);

   // Heap-ordered tree: node k has children 2k (lower lanes) and 2k+1; leaves at NLEAF+i.
   logic [WIDTH-1:0] w_max [1:2*NLEAF-1];
   logic [IDX_W-1:0] w_idx [1:2*NLEAF-1];
   logic [SUM_W-1:0] w_sum [1:2*NLEAF-1];
   logic [CNT_W-1:0] w_cnt [1:2*NLEAF-1];

   // Load the leaves, then fold pairs bottom-up towards the root at node 1.
   always_comb begin
      for (int i = 0; i < NLEAF; i++) begin
         w_max[NLEAF+i] = w_diff_pad[i*WIDTH +: WIDTH];
         w_idx[NLEAF+i] = IDX_W'(i);
         w_sum[NLEAF+i] = SUM_W'(w_diff_pad[i*WIDTH +: WIDTH]);
         w_cnt[NLEAF+i] = CNT_W'(w_over_pad[i]);
      end
      for (int k = NLEAF - 1; k >= 1; k--) begin
         if (w_max[2*k+1] > w_max[2*k]) begin
            w_max[k] = w_max[2*k+1];
            w_idx[k] = w_idx[2*k+1];
         end else begin
            w_max[k] = w_max[2*k];
            w_idx[k] = w_idx[2*k];
         end
         w_sum[k] = w_sum[2*k] + w_sum[2*k+1];
         w_cnt[k] = w_cnt[2*k] + w_cnt[2*k+1];
      end
   end

   assign o_max = w_max[1];
   assign o_idx = w_idx[1];
   assign o_sum = w_sum[1];
   assign o_cnt = w_cnt[1];

endmodule

// File: rtl/vector_diff_pipe.sv
// vector_diff_pipe: three-stage streaming vector difference unit with valid/ready on both
// sides and a single global stall enable.
module vector_diff_pipe
   import vdiff_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned LANES = 4,
   localparam int unsigned IDX_W = idx_w(LANES),
   localparam int unsigned SUM_W = sum_w(WIDTH, LANES),
   localparam int unsigned CNT_W = cnt_w(LANES)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] vec_new,
   input  logic [LANES*WIDTH-1:0] vec_old,
   input  logic [WIDTH-1:0]       thresh,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       max_diff,
   output logic [IDX_W-1:0]       max_idx,
   output logic [SUM_W-1:0]       sum_diff,
   output logic [CNT_W-1:0]       over_cnt
);

   // Whole pipe moves together; bubbles are kept, so stall depends only on the output stage.
   logic w_adv;
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   logic                   r_s1_valid;
   logic [LANES*WIDTH-1:0] r_s1_new;
   logic [LANES*WIDTH-1:0] r_s1_old;
   logic [WIDTH-1:0]       r_s1_thresh;

   logic                   r_s2_valid;
   logic [LANES*WIDTH-1:0] r_s2_diff;
   logic [LANES-1:0]       r_s2_over;

   logic                   r_s3_valid;
   logic [WIDTH-1:0]       r_max;
   logic [IDX_W-1:0]       r_idx;
   logic [SUM_W-1:0]       r_sum;
   logic [CNT_W-1:0]       r_cnt;

   logic [LANES*WIDTH-1:0] w_diff;
   logic [LANES-1:0]       w_over;

   // Per-lane magnitude written as a compare-and-subtract so it never wraps.
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [WIDTH-1:0] w_a;
      logic [WIDTH-1:0] w_b;
      logic [WIDTH-1:0] w_d;
      assign w_a = r_s1_new[g*WIDTH +: WIDTH];
      assign w_b = r_s1_old[g*WIDTH +: WIDTH];
      assign w_d = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
      assign w_diff[g*WIDTH +: WIDTH] = w_d;
      assign w_over[g] = w_d > r_s1_thresh;
   end

   logic [WIDTH-1:0] w_red_max;
   logic [IDX_W-1:0] w_red_idx;
   logic [SUM_W-1:0] w_red_sum;
   logic [CNT_W-1:0] w_red_cnt;

   lane_reduce #(
      .WIDTH(WIDTH),
      .LANES(LANES)
   ) u_lane_reduce (
      .i_diff(r_s2_diff),
      .i_over(r_s2_over),
      .o_max (w_red_max),
      .o_idx (w_red_idx),
      .o_sum (w_red_sum),
      .o_cnt (w_red_cnt)
   );

   // S1: capture the incoming beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_new    <= '0;
         r_s1_old    <= '0;
         r_s1_thresh <= '0;
      end else if (w_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_new    <= vec_new;
            r_s1_old    <= vec_old;
            r_s1_thresh <= thresh;
         end
      end
   end

   // S2: register per-lane differences and threshold compares.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s2_valid <= 1'b0;
         r_s2_diff  <= '0;
         r_s2_over  <= '0;
      end else if (w_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_diff <= w_diff;
            r_s2_over <= w_over;
         end
      end
   end

   // S3: register the reductions directly onto the outputs; data only moves with a real beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s3_valid <= 1'b0;
         r_max      <= '0;
         r_idx      <= '0;
         r_sum      <= '0;
         r_cnt      <= '0;
      end else if (w_adv) begin
         r_s3_valid <= r_s2_valid;
         if (r_s2_valid) begin
            r_max <= w_red_max;
            r_idx <= w_red_idx;
            r_sum <= w_red_sum;
            r_cnt <= w_red_cnt;
         end
      end
   end

   assign out_valid = r_s3_valid;
   assign max_diff  = r_max;
   assign max_idx   = r_idx;
   assign sum_diff  = r_sum;
   assign over_cnt  = r_cnt;

endmodule
